// File: rtl/frame_strobe_gen.sv
// frame_strobe_gen: column-level frame-write sequencer.
// Accepts a {column, frame} command and decodes it. For a command aimed at this
// column with a legal frame index, it drives a single registered one-hot
// FrameStrobe pulse, framed by programmable setup and hold windows. Commands for
// other columns are accepted and dropped, so one command bus can feed every
// column instance.
module frame_strobe_gen #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int ColSelectWidth   = 5,
  parameter int Col              = 0,
  parameter int SetupCycles      = 1,
  parameter int StrobeCycles     = 1,
  parameter int HoldCycles       = 1
) (
  input  logic                                     CLK,
  input  logic                                     resetn,
  input  logic                                     cmd_valid,
  output logic                                     cmd_ready,
  input  logic [ColSelectWidth+FrameSelectWidth-1:0] cmd_addr,
  output logic [MaxFramesPerCol-1:0]               FrameStrobe,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  input  logic                                     err_clr
);

  // The counter must hold the index of the last cycle of the longest phase.
  localparam int MAX_SP  = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
  localparam int MAX_CYC = (MAX_SP > HoldCycles) ? MAX_SP : HoldCycles;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  // Counter value reached in the final cycle of each phase. A zero-length
  // phase is never entered, so its value does not matter.
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'((SetupCycles  > 0) ? SetupCycles  - 1 : 0);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'((StrobeCycles > 0) ? StrobeCycles - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HoldCycles   > 0) ? HoldCycles   - 1 : 0);

  localparam logic [ColSelectWidth-1:0]  COL_SEL    = ColSelectWidth'(Col);
  localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = MaxFramesPerCol'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [FrameSelectWidth-1:0] idx_q, idx_d;
  logic [MaxFramesPerCol-1:0]  strobe_d;
  logic                        done_d;
  logic                        err_set;
  logic                        err_d;

  logic [ColSelectWidth-1:0]   col_field;
  logic [FrameSelectWidth-1:0] frame_field;
  logic                        col_match;
  logic                        frame_oor;

  // Decode the command fields. The all-ones column address is a broadcast.
  always_comb begin
    col_field   = cmd_addr[FrameSelectWidth +: ColSelectWidth];
    frame_field = cmd_addr[FrameSelectWidth-1:0];
    col_match   = (col_field == COL_SEL) || (&col_field);
    frame_oor   = (32'(frame_field) >= 32'(MaxFramesPerCol));
  end

  // Sequencer next state: IDLE -> [SETUP] -> STROBE -> [HOLD] -> IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && col_match) begin
          if (frame_oor) begin
            err_set = 1'b1;
          end else begin
            idx_d   = frame_field;
            state_d = (SetupCycles > 0) ? SETUP : STROBE;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          if (HoldCycles > 0) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase counter restarts on every state change and rests at zero in IDLE.
  always_comb begin
    if ((state_d != state_q) || (state_d == IDLE)) cnt_d = '0;
    else                                           cnt_d = cnt_q + CNT_W'(1);
  end

  // The strobe is computed from the next state so that the flop output is high
  // exactly for the cycles spent in STROBE. This keeps it single-hot and glitch-free.
  always_comb begin
    strobe_d = '0;
    if (state_d == STROBE) strobe_d = STROBE_ONE << idx_d;
  end

  // A sticky error flag. A new error in the same cycle as a clear takes priority.
  always_comb begin
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err;
  end

  // Control state and registered outputs. Reset drops the strobe asynchronously.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      FrameStrobe <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      FrameStrobe <= strobe_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

  // Latched frame index. It is only meaningful after an accept, so it needs no reset.
  always_ff @(posedge CLK) begin
    idx_q <= idx_d;
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule
